fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the multicycle control unit.
- Holds the PC and computes the next PC when the control unit pulses updPC, using brOp and a branch-condition operand.
- Fetches the instruction word over a req/ack instruction-memory handshake and latches it into the IR.
- Presents the decoded fields: opcode, func, register indices and immediate.

---
 rtl/fetch_unit_if.sv | 13 +
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit and its memory.
// The fetch side drives the request and address; memory returns data with a one-cycle ack.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ack;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches into the IR over a req/ack channel,
// and steps or branches the PC when the control unit raises updPC.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              updPC,
  input  logic [2:0]        brOp,
  input  logic [31:0]       rs_val,
  fetch_unit_if.master      imem,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        func,
  output logic [15:0]       imm16,
  output logic              instr_valid,
  output logic              br_taken,
  output logic              upd_overrun
);

  localparam int unsigned OFF_W = 18;

  typedef enum logic [1:0] {BOOT, FETCH, IDLE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic              taken_q, taken_d;
  logic              over_q, over_d;
  logic              pend_q, pend_d;
  logic [2:0]        pend_op_q, pend_op_d;
  logic [31:0]       pend_rs_q, pend_rs_d;
  logic              upd_prev_q;

  logic              upd_edge;
  logic [2:0]        sel_op;
  logic [31:0]       sel_rs;
  logic              take;
  logic signed [OFF_W-1:0] off_raw;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] pc_next;

  function automatic logic br_cond(input logic [2:0] op, input logic [31:0] v);
    case (op)
      3'b000:  return 1'b1;
      3'b001:  return v[31];
      3'b010:  return !v[31] && (v != 32'd0);
      3'b011:  return v == 32'd0;
      default: return 1'b0;
    endcase
  endfunction

  // A queued request carries its own branch operands; otherwise use the live ones.
  always_comb begin
    upd_edge = updPC & ~upd_prev_q;
    sel_op   = pend_q ? pend_op_q : brOp;
    sel_rs   = pend_q ? pend_rs_q : rs_val;
    take     = br_cond(sel_op, sel_rs);
    off_raw  = $signed({instr_q[15:0], 2'b00});
    br_off   = ADDR_W'(off_raw);
    pc_next  = pc_q + (take ? br_off : ADDR_W'(4));
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    req_d     = req_q;
    taken_d   = taken_q;
    over_d    = over_q;
    pend_d    = pend_q;
    pend_op_d = pend_op_q;
    pend_rs_d = pend_rs_q;

    // Updates arriving before IDLE wait in a one-deep slot; extras are flagged.
    if (state_q != IDLE && upd_edge) begin
      if (pend_q) begin
        over_d = 1'b1;
      end else begin
        pend_d    = 1'b1;
        pend_op_d = brOp;
        pend_rs_d = rs_val;
      end
    end

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (upd_edge || pend_q) begin
          pc_d    = pc_next;
          taken_d = take;
          valid_d = 1'b0;
          req_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = FETCH;
          if (pend_q && upd_edge) over_d = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      taken_q    <= 1'b0;
      over_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_op_q  <= '0;
      pend_rs_q  <= '0;
      upd_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      taken_q    <= taken_d;
      over_q     <= over_d;
      pend_q     <= pend_d;
      pend_op_q  <= pend_op_d;
      pend_rs_q  <= pend_rs_d;
      upd_prev_q <= updPC;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign br_taken       = taken_q;
  assign upd_overrun    = over_q;
  assign opcode         = instr_q[31:26];
  assign rs             = instr_q[25:21];
  assign rt             = instr_q[20:16];
  assign rd             = instr_q[15:11];
  assign func           = instr_q[4:0];
  assign imm16          = instr_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: wait-state memory responder, transaction-level reference model
// compared every cycle, and directed branch / overrun / reset / wrap scenarios.
module tb_fetch_unit;
  localparam int unsigned AW  = 16;
  localparam logic [15:0] RPC = 16'h0010;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        updPC  = 1'b0;
  logic [2:0]  brOp   = 3'b100;
  logic [31:0] rs_val = 32'd0;

  logic [15:0] pc;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, func;
  logic [15:0] imm16;
  logic        instr_valid, br_taken, upd_overrun;

  fetch_unit_if #(.ADDR_W(AW)) bus ();

  fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst_n), .updPC(updPC), .brOp(brOp), .rs_val(rs_val),
    .imem(bus), .pc(pc), .instr(instr), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .func(func), .imm16(imm16), .instr_valid(instr_valid),
    .br_taken(br_taken), .upd_overrun(upd_overrun)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Memory image: a few branch words at chosen addresses, a recognisable pattern elsewhere.
  logic [31:0] mem [int];
  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {16'hC0DE ^ a, a};
  endfunction
  function automatic logic [31:0] br_word(input logic [15:0] imm);
    return {6'h04, 5'd1, 5'd2, imm};
  endfunction

  int wait_cycles = 2;
  bit ack_in_rst  = 1'b0;
  int mcnt        = 0;

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mcnt         = 0;
        bus.imem_ack = ack_in_rst;
        if (ack_in_rst) bus.imem_rdata = 32'hDEAD_BEEF;
      end else if (bus.imem_ack) begin
        bus.imem_ack = 1'b0;
        mcnt         = 0;
      end else if (bus.imem_req) begin
        if (mcnt == wait_cycles) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_rd(bus.imem_addr);
        end else begin
          mcnt++;
        end
      end
    end
  end

  // Reference model: a fetch in flight, a boot cycle, and a FIFO of deferred updates (max 1).
  typedef struct { logic [2:0] op; logic [31:0] v; } upd_t;
  upd_t        m_pend[$];
  logic [15:0] m_pc;
  logic [31:0] m_instr;
  bit          m_valid, m_req, m_taken, m_over, m_boot, m_prev;
  bit          m_e;
  upd_t        m_u, m_w;

  function automatic bit taken_rule(input logic [2:0] op, input logic [31:0] v);
    if (op == 3'd0) return 1'b1;
    if (op == 3'd1) return $signed(v) < 0;
    if (op == 3'd2) return $signed(v) > 0;
    if (op == 3'd3) return v == 32'd0;
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_pend.delete();
    m_pc = RPC; m_instr = 32'd0;
    m_valid = 0; m_req = 0; m_taken = 0; m_over = 0; m_boot = 1; m_prev = 0;
  endtask

  task automatic m_note(input bit e, input upd_t u);
    if (e) begin
      if (m_pend.size() > 0) m_over = 1;
      else m_pend.push_back(u);
    end
  endtask

  task automatic m_apply(input upd_t w);
    bit t;
    int step;
    t       = taken_rule(w.op, w.v);
    step    = t ? int'($signed(m_instr[15:0])) * 4 : 4;
    m_pc    = 16'(int'(m_pc) + step);
    m_taken = t;
    m_valid = 0;
    m_req   = 1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        m_e    = updPC && !m_prev;
        m_prev = updPC;
        m_u.op = brOp;
        m_u.v  = rs_val;
        if (m_boot) begin
          m_boot = 0;
          m_note(m_e, m_u);
          m_req = 1;
        end else if (m_req) begin
          m_note(m_e, m_u);
          if (bus.imem_ack) begin
            m_instr = bus.imem_rdata;
            m_valid = 1;
            m_req   = 0;
          end
        end else if (m_pend.size() > 0 || m_e) begin
          if (m_pend.size() > 0) begin
            m_w = m_pend.pop_front();
            if (m_e) m_over = 1;
          end else begin
            m_w = m_u;
          end
          m_apply(m_w);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    chk("req",    32'(bus.imem_req),  32'(m_req));
    chk("addr",   32'(bus.imem_addr), 32'(m_pc));
    chk("pc",     32'(pc),            32'(m_pc));
    chk("instr",  instr,              m_instr);
    chk("valid",  32'(instr_valid),   32'(m_valid));
    chk("taken",  32'(br_taken),      32'(m_taken));
    chk("over",   32'(upd_overrun),   32'(m_over));
    chk("opcode", 32'(opcode),        32'(m_instr[31:26]));
    chk("rs",     32'(rs),            32'(m_instr[25:21]));
    chk("rt",     32'(rt),            32'(m_instr[20:16]));
    chk("rd",     32'(rd),            32'(m_instr[15:11]));
    chk("func",   32'(func),          32'(m_instr[4:0]));
    chk("imm16",  32'(imm16),         32'(m_instr[15:0]));
  end

  task automatic pulse(input logic [2:0] op, input logic [31:0] v);
    @(negedge clk);
    updPC = 1'b1; brOp = op; rs_val = v;
    @(negedge clk);
    updPC = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(instr_valid && !bus.imem_req) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 40), 32'd1);
  endtask

  task automatic step(input string name, input logic [2:0] op, input logic [31:0] v,
                      input logic [15:0] exp_pc, input bit exp_t);
    pulse(op, v);
    wait_idle({name, "_done"});
    chk({name, "_pc"},    32'(pc),       32'(exp_pc));
    chk({name, "_taken"}, 32'(br_taken), 32'(exp_t));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    mem[32'h10] = 32'h1234_5678;
    mem[32'h14] = br_word(16'h0003);
    mem[32'h18] = br_word(16'h0002);
    mem[32'h20] = br_word(16'hFFFE);
    mem[32'h24] = br_word(16'h0001);
    mem[32'h2C] = br_word(16'h0001);
    mem[32'h44] = br_word(16'h3FEE);

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("boot_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    chk("fetch0_req",  32'(bus.imem_req),  32'd1);
    chk("fetch0_addr", 32'(bus.imem_addr), 32'h0010);
    repeat (2) @(negedge clk);
    chk("fetch0_wait_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("fetch0_valid", 32'(instr_valid), 32'd1);
    chk("fetch0_instr", instr,            32'h1234_5678);

    pulse(3'b100, 32'd0);
    chk("nobr_req",  32'(bus.imem_req),  32'd1);
    chk("nobr_addr", 32'(bus.imem_addr), 32'h0014);
    wait_idle("nobr_done");
    chk("nobr_taken", 32'(br_taken), 32'd0);

    step("br",       3'b000, 32'd0,         16'h0020, 1'b1);
    step("bz_t",     3'b011, 32'd0,         16'h0018, 1'b1);
    step("br2",      3'b000, 32'd0,         16'h0020, 1'b1);
    step("bz_nt",    3'b011, 32'd5,         16'h0024, 1'b0);
    step("bmi_neg",  3'b001, 32'h8000_0000, 16'h0028, 1'b1);
    step("bpl_neg",  3'b010, 32'h8000_0000, 16'h002C, 1'b0);
    step("bpl_pos",  3'b010, 32'd1,         16'h0030, 1'b1);
    step("bmi_zero", 3'b001, 32'd0,         16'h0034, 1'b0);
    step("bpl_zero", 3'b010, 32'd0,         16'h0038, 1'b0);
    step("op111",    3'b111, 32'd0,         16'h003C, 1'b0);

    // Two edges during a long fetch: one queued, one dropped.
    wait_cycles = 5;
    pulse(3'b100, 32'd0);
    pulse(3'b100, 32'd0);
    chk("ovr_first", 32'(upd_overrun), 32'd0);
    pulse(3'b100, 32'd0);
    chk("ovr_second", 32'(upd_overrun), 32'd1);
    wait_idle("ovr_fetch_done");
    chk("ovr_pc_at_ack", 32'(pc), 32'h0040);
    @(negedge clk);
    chk("ovr_serviced_pc",  32'(pc),           32'h0044);
    chk("ovr_serviced_req", 32'(bus.imem_req), 32'd1);
    wait_idle("ovr_done");
    chk("ovr_final_pc", 32'(pc), 32'h0044);
    wait_cycles = 2;

    step("to_top", 3'b000, 32'd0, 16'hFFFC, 1'b1);
    step("wrap",   3'b100, 32'd0, 16'h0000, 1'b0);

    // Reset in the middle of a fetch, with ack held during reset.
    wait_cycles = 5;
    pulse(3'b100, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    ack_in_rst = 1'b1;
    #1;
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid),  32'd0);
    chk("rst_pc",    32'(pc),           32'h0010);
    chk("rst_over",  32'(upd_overrun),  32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    ack_in_rst = 1'b0;
    wait_cycles = 2;
    @(negedge clk);
    chk("rst_boot_ign_valid", 32'(instr_valid), 32'd0);
    chk("rst_boot_ign_instr", instr,            32'd0);
    wait_idle("refetch_done");
    chk("refetch_pc",    32'(pc), 32'h0010);
    chk("refetch_instr", instr,   32'h1234_5678);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
